// File: rtl/mac_operand_loader.sv
// Operand loader for the dlfloat MAC: pairs consecutive input words into (A, B) and
// queues them in a small FIFO that feeds the MAC over a valid/ready handshake.
module mac_operand_loader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [W-1:0]                 op_a,
  output logic [W-1:0]                 op_b,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  pair_count,
  output logic                         drop_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic {StGetA, StGetB} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    stage_q, stage_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     pair_count_q, pair_count_d;
  logic            drop_q, drop_d;

  logic [W-1:0]    mem_a [DEPTH];
  logic [W-1:0]    mem_b [DEPTH];

  logic accept, push, pop;

  // in_ready depends on registered state only, so upstream sees no combinational path.
  assign in_ready   = (state_q == StGetA) || (count_q < DepthCnt);
  assign op_valid   = (count_q != '0);
  assign op_a       = op_valid ? mem_a[rd_ptr_q] : '0;
  assign op_b       = op_valid ? mem_b[rd_ptr_q] : '0;
  assign count      = count_q;
  assign pair_count = pair_count_q;
  assign drop_err   = drop_q;

  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && (state_q == StGetB);
  assign pop    = op_valid && op_ready && !flush;

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pair_count_d = pair_count_q;
    drop_d       = drop_q;

    if (flush) begin
      state_d      = StGetA;
      stage_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pair_count_d = '0;
      drop_d       = 1'b0;
    end else begin
      if (accept) begin
        if (state_q == StGetA) begin
          stage_d = data_in;
          state_d = StGetB;
        end else begin
          state_d = StGetA;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PtrW'(1);
        pair_count_d = pair_count_q + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && !in_ready) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StGetA;
      stage_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pair_count_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pair_count_q <= pair_count_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= stage_q;
      mem_b[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: a queue-based pair model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_mac_operand_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 16;

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    count;
  logic [15:0]   pair_count;
  logic          drop_err;

  mac_operand_loader #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .count      (count),
    .pair_count (pair_count),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of {A,B} pairs, whether the next word is a B, the staged A.
  logic [31:0] mq[$];
  bit          m_want_b;
  logic [15:0] m_staged;
  logic [15:0] m_pc;
  bit          m_drop;

  logic [15:0] fa [5] = '{16'hBE00, 16'h0000, 16'h7FFF, 16'h1234, 16'h1111};
  logic [15:0] fb [5] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0200, 16'h2222};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_want_b = 1'b0;
    m_staged = '0;
    m_pc     = '0;
    m_drop   = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy;
    if (!rst || flush) begin
      model_reset();
    end else begin
      rdy = !m_want_b || (mq.size() < DEPTH);
      if (in_valid && !rdy) m_drop = 1'b1;
      if (mq.size() != 0 && op_ready) begin
        void'(mq.pop_front());
        m_pc = m_pc + 16'd1;
      end
      if (in_valid && rdy) begin
        if (!m_want_b) begin
          m_staged = data_in;
          m_want_b = 1'b1;
        end else begin
          mq.push_back({m_staged, data_in});
          m_want_b = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] head;
    head = (mq.size() != 0) ? mq[0] : 32'h0;
    check("in_ready",   32'(in_ready),   32'(!m_want_b || (mq.size() < DEPTH)));
    check("op_valid",   32'(op_valid),   32'(mq.size() != 0));
    check("op_a",       32'(op_a),       32'(head[31:16]));
    check("op_b",       32'(op_b),       32'(head[15:0]));
    check("count",      32'(count),      32'(mq.size()));
    check("pair_count", 32'(pair_count), 32'(m_pc));
    check("drop_err",   32'(drop_err),   32'(m_drop));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    in_valid = v;
    data_in  = d;
    op_ready = r;
    flush    = f;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    drive(1'b1, a, 1'b0, 1'b0);
    step();
    drive(1'b1, b, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    check("rst_op_valid", 32'(op_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_count",    32'(count),    32'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_op_valid", 32'(op_valid), 32'h0);

    // Single pair.
    push_pair(16'h3E00, 16'h4000);
    check("single_valid", 32'(op_valid), 32'h1);
    check("single_a",     32'(op_a),     32'h3E00);
    check("single_b",     32'(op_b),     32'h4000);
    check("single_count", 32'(count),    32'h1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("single_pop_valid", 32'(op_valid),   32'h0);
    check("single_pop_a",     32'(op_a),       32'h0);
    check("single_pop_pc",    32'(pair_count), 32'h1);

    // Fill the FIFO, then backpressure on the fifth B word.
    for (int i = 0; i < 4; i++) push_pair(fa[i], fb[i]);
    check("full_count", 32'(count), 32'h4);
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    step();
    check("full_a_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    step();
    check("full_drop", 32'(drop_err), 32'h1);
    check("full_hold", 32'(in_ready), 32'h0);
    check("full_head_a", 32'(op_a), 32'(fa[0]));
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    check("full_ready_back", 32'(in_ready), 32'h1);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    step();
    check("full_refill_count", 32'(count), 32'h4);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      check("drain_a", 32'(op_a), 32'(fa[i]));
      check("drain_b", 32'(op_b), 32'(fb[i]));
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("drain_pc", 32'(pair_count), 32'd6);

    // Push and pop on the same edge.
    push_pair(16'h0A01, 16'h0B01);
    push_pair(16'h0A02, 16'h0B02);
    drive(1'b1, 16'h0A03, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0B03, 1'b1, 1'b0);
    step();
    check("simul_count", 32'(count),      32'h2);
    check("simul_pc",    32'(pair_count), 32'd7);
    check("simul_head",  32'(op_a),       32'h0A02);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    check("simul_tail", {16'(op_a), 16'(op_b)}, 32'h0A03_0B03);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Flush mid-pair with a word and a pop offered.
    for (int i = 1; i < 4; i++) push_pair(16'h0C00 + 16'(i), 16'h0D00 + 16'(i));
    drive(1'b1, 16'h0C04, 1'b0, 1'b0);
    step();
    check("pre_flush_count", 32'(count),    32'h3);
    check("pre_flush_drop",  32'(drop_err), 32'h1);
    drive(1'b1, 16'h0D04, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("flush_count", 32'(count),      32'h0);
    check("flush_pc",    32'(pair_count), 32'h0);
    check("flush_drop",  32'(drop_err),   32'h0);
    push_pair(16'hAAAA, 16'h5555);
    check("post_flush_pair", {16'(op_a), 16'(op_b)}, 32'hAAAA_5555);

    // Asynchronous reset between edges.
    push_pair(16'h0001, 16'h0002);
    check("pre_rst_count", 32'(count), 32'h2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_count", 32'(count),    32'h0);
    check("async_valid", 32'(op_valid), 32'h0);
    check("async_a",     32'(op_a),     32'h0);
    step();
    rst = 1'b1;
    step();
    push_pair(16'h00FF, 16'hFF00);
    check("post_rst_pair", {16'(op_a), 16'(op_b)}, 32'h00FF_FF00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_operand_loader.md
# mac_operand_loader

Upstream operand stage for the dlfloat MAC. It assembles consecutive 16-bit words from the shared input bus into (A, B) operand pairs, with the first word of a pair being A and the second B. Pairs are buffered in a small FIFO and presented to the MAC through a valid/ready handshake. When the FIFO is empty it drives zero operands, so the free-running MAC accumulates a zero product.

## Interface
Parameters:
- DEPTH, 4, pair FIFO depth; power of two, ≥2
- W, 16, operand width (dlfloat16: 1 sign, 6 exponent with bias 31, 9 mantissa)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  W  operand word from pins
- in_valid  in  1  data_in present this cycle
- in_ready  out  1  loader accepts data_in this cycle
- flush  in  1  synchronous clear of all loader state
- op_a  out  W  A operand of FIFO head; 0 when op_valid=0
- op_b  out  W  B operand of FIFO head; 0 when op_valid=0
- op_valid  out  1  head pair available
- op_ready  in  1  MAC consumes head pair
- count  out  $clog2(DEPTH+1)  pairs held in FIFO
- pair_count  out  16  pairs delivered since reset/flush; wraps at 2^16
- drop_err  out  1  sticky: a word was offered while in_ready=0

## Operation
- A word is accepted when in_valid && in_ready. A pair is popped when op_valid && op_ready.
- Assembly FSM has two states:
  - GET_A (reset state): an accepted word is latched into the staging register; next state GET_B.
  - GET_B: an accepted word is pushed to the FIFO together with staging as {A=staging, B=data_in}; next state GET_A.
  - With no accepted word, the FSM holds its state.
- in_ready = (state==GET_A) || (count<DEPTH).
  - in_ready is a function of registered state only. It has no combinational path from op_ready or in_valid.
- FIFO behaviour:
  - Write pointer and read pointer wrap modulo DEPTH.
  - Pairs are output in arrival order.
  - op_valid = (count!=0).
  - op_a/op_b are read combinationally from the head entry and forced to 0 when the FIFO is empty.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - A push never occurs while full, because in_ready=0 in GET_B when full.
- pair_count increments by 1 on each pop and wraps 0xFFFF→0x0000.
- drop_err:
  - Set on any cycle with in_valid && !in_ready && !flush.
  - Remains set until flush or reset.
  - The dropped word does not advance the FSM.
- flush has priority over push, pop and drop. In a flush cycle:
  - FSM→GET_A; pointers, count, pair_count and drop_err →0; staging →0.
  - A word or pop offered in the same cycle is ignored; no pair is consumed.
  - FIFO storage contents need not be cleared.
- Operands are not checked; the loader transports words bit-exact, including zero, denormal and negative values.

## Timing
- Reset (rst=0, asynchronous) drives these outputs to 0: op_a, op_b, op_valid, count, pair_count, drop_err. in_ready=1 and FSM=GET_A. Deasserting reset mid-pair discards any staged A.
- Latency, B word to MAC: B is accepted at edge N. At edge N the pair is written, and op_valid/op_a/op_b are valid in the cycle after edge N. If the FIFO was empty, that is one cycle after B is presented.
- A pop at edge M makes the next head, or zeros if empty, visible after edge M.
- Throughput is at most one pair every 2 cycles, limited by input bus width. The output side can pop one pair per cycle.
- Full FIFO in GET_B: in_ready=0 until a pop edge; in_ready rises the cycle after that pop.
- GET_A while full: A is still accepted into staging.

## Test plan
- Reset: hold rst=0 with random inputs → op_valid=0, op_a=op_b=0, count=0, pair_count=0, drop_err=0, in_ready=1; release and check state stays idle.
- Single pair:
  - Stimulus: data_in 0x3E00 then 0x4000 with in_valid, op_ready=0.
  - Next cycle: op_valid=1, op_a=0x3E00, op_b=0x4000, count=1.
  - Then pulse op_ready=1 for one cycle: op_valid=0, op_a=0, count=0, pair_count=1.
- Full/backpressure:
  - With op_ready=0, push 4 pairs → count=4.
  - A5=0x1111 is accepted and in_ready drops to 0.
  - Offer B5=0x2222 while in_ready=0 → drop_err=1; state stays GET_B.
  - Pulse op_ready for one cycle; re-offer 0x2222 once in_ready=1 → FIFO tail holds {0x1111,0x2222}.
  - Pops then return pairs 1..4 and then pair 5, in order.
- Simultaneous push/pop:
  - With count=2, the B word is accepted in the same cycle as op_ready=1 → count stays 2, pair_count+1.
  - Remaining pairs are output in FIFO order.
- Flush mid-pair:
  - In GET_B with count=3 and drop_err=1, assert flush together with in_valid and op_ready → count=0, op_valid=0, pair_count=0, drop_err=0.
  - The next word is treated as A.
- Async reset mid-stream: assert rst between clock edges with count=2 → all outputs are 0 immediately, without waiting for a clock edge.
